// File: rtl/video_mixer_pipe.sv
// Four-stage video output mixer: source select, scanlines, RGB->YPbPr matrix,
// clamp/stretch and sync shaping. Mode inputs are latched on the selected vsync rising edge.
module video_mixer_pipe #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 6
) (
    input  logic             clk,
    input  logic             _reset,
    input  logic             ce_pix,
    input  logic             scandoubler_disable,
    input  logic             ypbpr,
    input  logic             ypbpr_full,
    input  logic [1:0]       scanlines,
    input  logic [IN_W-1:0]  r_i,
    input  logic [IN_W-1:0]  g_i,
    input  logic [IN_W-1:0]  b_i,
    input  logic             hsync_i,
    input  logic             vsync_i,
    input  logic [IN_W-1:0]  r_p,
    input  logic [IN_W-1:0]  g_p,
    input  logic [IN_W-1:0]  b_p,
    input  logic             hsync_p,
    input  logic             vsync_p,
    output logic [OUT_W-1:0] VGA_R,
    output logic [OUT_W-1:0] VGA_G,
    output logic [OUT_W-1:0] VGA_B,
    output logic             VGA_HS,
    output logic             VGA_VS
);
    typedef struct packed {
        logic       sd;
        logic       ypbpr;
        logic       full;
        logic [1:0] sl;
    } mode_t;

    typedef struct packed {
        logic sd;
        logic ypbpr;
        logic full;
    } pmode_t;

    mode_t       r_mode_lat, r_mode0;
    pmode_t      r_pm1, r_pm2;
    logic [7:0]  r_c0 [3];
    logic [7:0]  r_c1 [3];
    logic [7:0]  r_c2 [3];
    logic [10:0] r_m2 [3];
    logic        r_hs0, r_vs0, r_hs0_d, r_vs0_d;
    logic        r_hs1, r_vs1, r_hs2, r_vs2, r_par;

    logic [7:0]  w_src [3];
    logic [7:0]  w_s1  [3];
    logic [7:0]  w_out [3];
    logic        w_hs_sel, w_vs_sel, w_vs_edge;
    logic        w_hs_rise, w_vs_rise, w_par_next, w_dark_en, w_csync;
    logic [18:0] w_cr, w_cg, w_cb, w_y, w_pb, w_pr;

    function automatic logic [7:0] darken(input logic [7:0] c, input logic [1:0] sl);
        case (sl)
            2'b01:   return c - (c >> 2);
            2'b10:   return c >> 1;
            2'b11:   return c >> 2;
            default: return c;
        endcase
    endfunction

    function automatic logic [7:0] clamp(input logic [10:0] v, input logic [7:0] hi);
        if (v < 11'd16)
            return 8'd16;
        if (v > {3'd0, hi})
            return hi;
        return v[7:0];
    endfunction

    function automatic logic [7:0] stretch(input logic [7:0] v);
        logic [15:0] p;
        p = ({8'd0, v} - 16'd16) * 16'd73;
        return (p[15:6] > 10'd255) ? 8'd255 : p[13:6];
    endfunction

    // S0: source selection driven by the latched mode
    assign w_src[0] = r_mode_lat.sd ? r_i[IN_W-1 -: 8] : r_p[IN_W-1 -: 8];
    assign w_src[1] = r_mode_lat.sd ? g_i[IN_W-1 -: 8] : g_p[IN_W-1 -: 8];
    assign w_src[2] = r_mode_lat.sd ? b_i[IN_W-1 -: 8] : b_p[IN_W-1 -: 8];
    assign w_hs_sel = r_mode_lat.sd ? hsync_i : hsync_p;
    assign w_vs_sel = r_mode_lat.sd ? vsync_i : vsync_p;
    assign w_vs_edge = w_vs_sel & ~r_vs0;

    // S1: line parity; vsync clear has priority over hsync toggle
    assign w_vs_rise  = r_vs0 & ~r_vs0_d;
    assign w_hs_rise  = r_hs0 & ~r_hs0_d;
    assign w_par_next = w_vs_rise ? 1'b0 : (w_hs_rise ? ~r_par : r_par);
    assign w_dark_en  = w_par_next & (r_mode0.sl != 2'b00) & ~r_mode0.sd;

    // S2: the bias terms keep every sum non-negative, so modulo arithmetic is exact
    assign w_cr = {11'd0, r_c1[0]};
    assign w_cg = {11'd0, r_c1[1]};
    assign w_cb = {11'd0, r_c1[2]};
    assign w_y  = 19'd4096  + 19'd66  * w_cr + 19'd129 * w_cg + 19'd25  * w_cb;
    assign w_pb = 19'd32768 - 19'd38  * w_cr - 19'd74  * w_cg + 19'd112 * w_cb;
    assign w_pr = 19'd32768 + 19'd112 * w_cr - 19'd94  * w_cg - 19'd18  * w_cb;

    assign w_csync = r_pm2.sd | r_pm2.ypbpr;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            // Channel 1 carries Y (limit 235); channels 0 and 2 carry Pr/Pb (limit 240)
            localparam logic [7:0] HI = (gi == 1) ? 8'd235 : 8'd240;
            assign w_s1[gi]  = w_dark_en ? darken(r_c0[gi], r_mode0.sl) : r_c0[gi];
            assign w_out[gi] = !r_pm2.ypbpr ? r_c2[gi] :
                               (r_pm2.full ? stretch(clamp(r_m2[gi], HI)) : clamp(r_m2[gi], HI));
        end
    endgenerate

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_mode_lat <= '0;
            r_mode0    <= '0;
            r_pm1      <= '0;
            r_pm2      <= '0;
            r_hs0      <= 1'b0;
            r_vs0      <= 1'b0;
            r_hs0_d    <= 1'b0;
            r_vs0_d    <= 1'b0;
            r_hs1      <= 1'b0;
            r_vs1      <= 1'b0;
            r_hs2      <= 1'b0;
            r_vs2      <= 1'b0;
            r_par      <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_c0[i] <= '0;
                r_c1[i] <= '0;
                r_c2[i] <= '0;
                r_m2[i] <= '0;
            end
            VGA_R  <= '0;
            VGA_G  <= '0;
            VGA_B  <= '0;
            VGA_HS <= 1'b1;
            VGA_VS <= 1'b1;
        end else if (ce_pix) begin
            for (int i = 0; i < 3; i++) begin
                r_c0[i] <= w_src[i];
                r_c1[i] <= w_s1[i];
                r_c2[i] <= r_c1[i];
            end
            r_hs0   <= w_hs_sel;
            r_vs0   <= w_vs_sel;
            r_hs0_d <= r_hs0;
            r_vs0_d <= r_vs0;
            r_mode0 <= r_mode_lat;
            if (w_vs_edge)
                r_mode_lat <= {scandoubler_disable, ypbpr, ypbpr_full, scanlines};

            r_par <= w_par_next;
            r_hs1 <= r_hs0;
            r_vs1 <= r_vs0;
            r_pm1 <= {r_mode0.sd, r_mode0.ypbpr, r_mode0.full};

            r_m2[0] <= 11'(w_pr >> 8);
            r_m2[1] <= 11'(w_y  >> 8);
            r_m2[2] <= 11'(w_pb >> 8);
            r_hs2   <= r_hs1;
            r_vs2   <= r_vs1;
            r_pm2   <= r_pm1;

            VGA_R  <= w_out[0][7 -: OUT_W];
            VGA_G  <= w_out[1][7 -: OUT_W];
            VGA_B  <= w_out[2][7 -: OUT_W];
            VGA_VS <= w_csync ? 1'b1 : r_vs2;
            VGA_HS <= w_csync ? ~(r_hs2 ^ r_vs2) : r_hs2;
        end
    end
endmodule

// File: tb/tb_video_mixer_pipe.sv
// Directed and randomized checks of video_mixer_pipe against an arithmetic
// per-pixel reference model with a 4-deep expected-output queue.
module tb_video_mixer_pipe;
    localparam int IN_W  = 8;
    localparam int OUT_W = 6;
    localparam int PW    = 3 * OUT_W + 2;

    logic clk = 1'b0;
    logic rst_n, ce_pix, scandoubler_disable, ypbpr, ypbpr_full;
    logic [1:0] scanlines;
    logic [IN_W-1:0] r_i, g_i, b_i, r_p, g_p, b_p;
    logic hsync_i, vsync_i, hsync_p, vsync_p;
    logic [OUT_W-1:0] VGA_R, VGA_G, VGA_B;
    logic VGA_HS, VGA_VS;
    logic [PW-1:0] outs;

    int compared = 0;
    int mismatched = 0;

    // reference model state
    bit m_sd, m_yp, m_full, par, p_hs, p_vs;
    int m_sl;
    logic [PW-1:0] q[$];
    logic [PW-1:0] cur;
    localparam logic [PW-1:0] ZERO_PIX = '0;
    localparam logic [PW-1:0] RST_OUT  = {{(PW-2){1'b0}}, 2'b11};

    video_mixer_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk(clk), ._reset(rst_n), .ce_pix(ce_pix),
        .scandoubler_disable(scandoubler_disable), .ypbpr(ypbpr), .ypbpr_full(ypbpr_full),
        .scanlines(scanlines),
        .r_i(r_i), .g_i(g_i), .b_i(b_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
        .r_p(r_p), .g_p(g_p), .b_p(b_p), .hsync_p(hsync_p), .vsync_p(vsync_p),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS)
    );

    assign outs = {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS};
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] model_pix(input int r, input int g, input int b,
                                                input bit hs, input bit vs, input bit sd,
                                                input bit yp, input bit full, input int sl,
                                                input bit odd);
        int c [3];
        int v [3];
        int hi;
        bit csync, ohs, ovs;
        c[0] = r; c[1] = g; c[2] = b;
        if (odd && sl != 0 && !sd)
            for (int i = 0; i < 3; i++)
                c[i] = (sl == 1) ? c[i] - c[i] / 4 : (sl == 2) ? c[i] / 2 : c[i] / 4;
        if (yp) begin
            v[0] = (32768 + 112 * c[0] - 94 * c[1] - 18 * c[2]) / 256;
            v[1] = (4096 + 66 * c[0] + 129 * c[1] + 25 * c[2]) / 256;
            v[2] = (32768 - 38 * c[0] - 74 * c[1] + 112 * c[2]) / 256;
            for (int i = 0; i < 3; i++) begin
                hi = (i == 1) ? 235 : 240;
                if (v[i] < 16) v[i] = 16;
                if (v[i] > hi) v[i] = hi;
                if (full) begin
                    v[i] = (v[i] - 16) * 73 / 64;
                    if (v[i] > 255) v[i] = 255;
                end
            end
        end else begin
            v = c;
        end
        csync = sd || yp;
        ohs = csync ? !(hs ^ vs) : hs;
        ovs = csync ? 1'b1 : vs;
        return {OUT_W'(v[0] >> (8 - OUT_W)), OUT_W'(v[1] >> (8 - OUT_W)),
                OUT_W'(v[2] >> (8 - OUT_W)), ohs, ovs};
    endfunction

    task automatic model_reset();
        m_sd = 0; m_yp = 0; m_full = 0; m_sl = 0;
        par = 0; p_hs = 0; p_vs = 0;
        q.delete();
        repeat (3) q.push_back(ZERO_PIX);
        cur = RST_OUT;
    endtask

    // One clock: model absorbs the pixel (if ce), then the DUT output is checked.
    task automatic cyc();
        logic [PW-1:0] e;
        int cr, cg, cb;
        bit shs, svs, vedge;
        if (ce_pix) begin
            cr  = m_sd ? int'(r_i) : int'(r_p);
            cg  = m_sd ? int'(g_i) : int'(g_p);
            cb  = m_sd ? int'(b_i) : int'(b_p);
            shs = m_sd ? hsync_i : hsync_p;
            svs = m_sd ? vsync_i : vsync_p;
            vedge = svs && !p_vs;
            if (vedge) par = 0;
            else if (shs && !p_hs) par = !par;
            e = model_pix(cr, cg, cb, shs, svs, m_sd, m_yp, m_full, m_sl, par);
            if (vedge) begin
                m_sd = scandoubler_disable; m_yp = ypbpr; m_full = ypbpr_full; m_sl = int'(scanlines);
            end
            p_hs = shs; p_vs = svs;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (ce_pix) cur = q.pop_front();
        chk("pipe", 32'(outs), 32'(cur));
    endtask

    task automatic run(input int n);
        ce_pix = 1'b1;
        repeat (n) cyc();
    endtask

    task automatic set_px(input int r, input int g, input int b);
        r_p = 8'(r); g_p = 8'(g); b_p = 8'(b);
        r_i = 8'($urandom); g_i = 8'($urandom); b_i = 8'($urandom);
    endtask

    task automatic vs_pulse();
        ce_pix = 1'b1; vsync_p = 1'b1; cyc(); vsync_p = 1'b0;
    endtask

    task automatic hs_pulse();
        ce_pix = 1'b1; hsync_p = 1'b1; cyc(); hsync_p = 1'b0;
    endtask

    task automatic check_const(input string tag, input int er, input int eg, input int eb);
        $display("step %s: R=%0d G=%0d B=%0d HS=%0b VS=%0b", tag, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS);
        if (er >= 0) chk({tag, "_R"}, 32'(VGA_R), 32'(er));
        if (eg >= 0) chk({tag, "_G"}, 32'(VGA_G), 32'(eg));
        if (eb >= 0) chk({tag, "_B"}, 32'(VGA_B), 32'(eb));
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        $display("step reset: R=%0d G=%0d B=%0d HS=%0b VS=%0b", VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS);
        chk("reset_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
        chk("reset_hs", 32'(VGA_HS), 32'd1);
        chk("reset_vs", 32'(VGA_VS), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_seg(input int n);
        for (int i = 0; i < n; i++) begin
            if (i % 40 == 0) begin
                scandoubler_disable = 1'($urandom_range(0, 1));
                ypbpr      = 1'($urandom_range(0, 1));
                ypbpr_full = 1'($urandom_range(0, 1));
                scanlines  = 2'($urandom_range(0, 3));
            end
            ce_pix = ($urandom_range(0, 3) != 0);
            r_p = 8'($urandom); g_p = 8'($urandom); b_p = 8'($urandom);
            r_i = 8'($urandom); g_i = 8'($urandom); b_i = 8'($urandom);
            hsync_p = (i % 9) < 2;
            vsync_p = (i % 83) < 3;
            hsync_i = (i % 17) < 3;
            vsync_i = (i % 131) < 4;
            if ($urandom_range(0, 15) == 0) hsync_p = ~hsync_p;
            cyc();
        end
    endtask

    initial begin
        rst_n = 1'b1; ce_pix = 1'b0;
        scandoubler_disable = 1'b0; ypbpr = 1'b0; ypbpr_full = 1'b0; scanlines = 2'b00;
        hsync_i = 1'b0; vsync_i = 1'b0; hsync_p = 1'b0; vsync_p = 1'b0;
        set_px(0, 0, 0);
        do_reset();

        // RGB passthrough of the progressive source
        set_px(255, 0, 128);
        vs_pulse();
        run(5);
        check_const("rgb", 63, 0, 32);
        hs_pulse();
        run(4);

        // limited-range YPbPr
        ypbpr = 1'b1; ypbpr_full = 1'b0;
        set_px(255, 255, 255);
        vs_pulse();
        run(5);
        check_const("ypbpr_white", 32, 58, 32);
        set_px(0, 0, 0);
        run(5);
        check_const("ypbpr_black", 32, 4, 32);

        // full-range YPbPr
        ypbpr_full = 1'b1;
        set_px(255, 255, 255);
        vs_pulse();
        run(5);
        check_const("full_white", 31, 62, 31);
        set_px(0, 0, 0);
        run(5);
        check_const("full_black", -1, 0, -1);
        set_px(0, 0, 255);
        run(5);
        check_const("full_blue", -1, -1, 63);

        // 50% scanlines on constant 200
        ypbpr = 1'b0; ypbpr_full = 1'b0; scanlines = 2'b10;
        set_px(200, 200, 200);
        vs_pulse();
        run(5);
        check_const("sl_even", 50, 50, 50);
        hs_pulse();
        run(5);
        check_const("sl_odd", 25, 25, 25);
        hs_pulse();
        run(5);
        check_const("sl_even2", 50, 50, 50);

        // mid-frame mode change is deferred; ce low holds outputs
        ypbpr = 1'b1;
        run(5);
        check_const("defer", 50, 50, 50);
        ce_pix = 1'b0;
        repeat (4) cyc();
        check_const("hold", 50, 50, 50);
        vs_pulse();
        run(5);
        check_const("new_mode", -1, 46, 32);

        // reset mid-line, recovery in RGB mode on the 4th ce cycle
        set_px(255, 255, 255);
        run(2);
        do_reset();
        run(3);
        check_const("rst_pipe3", 0, 0, 0);
        run(1);
        check_const("rst_pipe4", 63, 63, 63);

        rand_seg(300);
        rand_seg(300);
        do_reset();
        rand_seg(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
